buzz_arbiter: RTL



---
 rtl/buzz_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/buzz_arbiter.sv
// Piezo arbiter: alarm > chime > key, each with its own beep pattern and tone.
// Optional BUZZ_MUTE_EN adds a mute input that silences everything but ALARM_ON.
module buzz_arbiter #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int TONE_ALARM   = 2000,
  parameter int TONE_CHIME   = 1000,
  parameter int TONE_KEY     = 4000,
  parameter int ALARM_ON_MS  = 200,
  parameter int ALARM_OFF_MS = 200,
  parameter int CHIME_ON_MS  = 150,
  parameter int CHIME_OFF_MS = 150,
  parameter int KEY_MS       = 30
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       req_alarm,
  input  logic       req_chime,
  input  logic       req_key,
`ifdef BUZZ_MUTE_EN
  input  logic       mute,
`endif
  output logic       buz,
  output logic       busy,
  output logic [1:0] active_src
);

  localparam int DIV   = CLK_FREQ / 1000;
  localparam int MSWR  = $clog2(DIV);
  localparam int MSW   = (MSWR < 1) ? 1 : MSWR;
  localparam int TM_AC = (TONE_ALARM < TONE_CHIME) ? TONE_ALARM : TONE_CHIME;
  localparam int TMIN  = (TM_AC < TONE_KEY) ? TM_AC : TONE_KEY;
  localparam int TWR   = $clog2(CLK_FREQ / (2 * TMIN));
  localparam int TW    = (TWR < 1) ? 1 : TWR;

  localparam logic [MSW-1:0] MS_LAST = MSW'(DIV - 1);
  localparam logic [TW-1:0]  H_ALARM = TW'(CLK_FREQ / (2 * TONE_ALARM) - 1);
  localparam logic [TW-1:0]  H_CHIME = TW'(CLK_FREQ / (2 * TONE_CHIME) - 1);
  localparam logic [TW-1:0]  H_KEY   = TW'(CLK_FREQ / (2 * TONE_KEY) - 1);

  typedef enum logic [2:0] {
    IDLE, ALARM_ON, ALARM_OFF, CHIME_ON, CHIME_OFF, KEY_ON
  } state_t;

  state_t          state, state_n;
  logic [MSW-1:0]  ms_cnt;
  logic [15:0]     dur;
  logic [15:0]     phase_ms;
  logic [TW-1:0]   tone;
  logic [TW-1:0]   half;
  logic            beep;
  logic            pend;
  logic            buz_q;
  logic            tick, done, chg;
  logic            on_cur, on_nxt;
  logic            pset, pend_n;

  assign tick   = (ms_cnt == MS_LAST);
  assign done   = tick && (dur == phase_ms - 16'd1);
  assign chg    = (state_n != state);
  assign on_cur = state inside {ALARM_ON, CHIME_ON, KEY_ON};
  assign on_nxt = state_n inside {ALARM_ON, CHIME_ON, KEY_ON};

  always_ff @(posedge clk) begin
    if (reset_p) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (req_alarm)              state_n = ALARM_ON;
        else if (req_chime || pend) state_n = CHIME_ON;
        else if (req_key)           state_n = KEY_ON;
      end
      ALARM_ON, ALARM_OFF: begin
        if (!req_alarm) state_n = pend ? CHIME_ON : IDLE;
        else if (done)
          state_n = (state == ALARM_ON) ? ALARM_OFF : ALARM_ON;
      end
      CHIME_ON: begin
        if (req_alarm) state_n = ALARM_ON;
        else if (done) state_n = CHIME_OFF;
      end
      CHIME_OFF: begin
        if (req_alarm) state_n = ALARM_ON;
        else if (done) state_n = beep ? IDLE : CHIME_ON;
      end
      KEY_ON: begin
        if (req_alarm)      state_n = ALARM_ON;
        else if (req_chime) state_n = CHIME_ON;
        else if (done)      state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    active_src = 2'd0;
    half       = '0;
    phase_ms   = 16'd1;
    unique case (state)
      ALARM_ON:  begin active_src = 2'd3; half = H_ALARM; phase_ms = 16'(ALARM_ON_MS);  end
      ALARM_OFF: begin active_src = 2'd3; half = H_ALARM; phase_ms = 16'(ALARM_OFF_MS); end
      CHIME_ON:  begin active_src = 2'd2; half = H_CHIME; phase_ms = 16'(CHIME_ON_MS);  end
      CHIME_OFF: begin active_src = 2'd2; half = H_CHIME; phase_ms = 16'(CHIME_OFF_MS); end
      KEY_ON:    begin active_src = 2'd1; half = H_KEY;   phase_ms = 16'(KEY_MS);       end
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p || chg || state == IDLE) begin
      ms_cnt <= '0;
      dur    <= '0;
    end else if (tick) begin
      ms_cnt <= '0;
      dur    <= dur + 16'd1;
    end else begin
      ms_cnt <= ms_cnt + MSW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      tone  <= '0;
      buz_q <= 1'b0;
    end else if (on_nxt && chg) begin
      tone  <= '0;
      buz_q <= 1'b1;
    end else if (on_cur && !chg) begin
      if (tone == half) begin
        tone  <= '0;
        buz_q <= ~buz_q;
      end else begin
        tone  <= tone + TW'(1);
      end
    end else begin
      tone  <= '0;
      buz_q <= 1'b0;
    end
  end

  // A chime request seen while alarm/chime owns the piezo, or a chime cut
  // short by the alarm, is remembered once and replayed later.
  assign pset = (req_chime &&
                 ((state inside {ALARM_ON, ALARM_OFF, CHIME_ON, CHIME_OFF}) ||
                  state_n == ALARM_ON)) ||
                (req_alarm && (state inside {CHIME_ON, CHIME_OFF}));
  assign pend_n = (state_n == CHIME_ON && chg) ? 1'b0 : pend;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      pend <= 1'b0;
      beep <= 1'b0;
    end else begin
      pend <= pend_n | pset;
      if (state_n == CHIME_ON && chg) beep <= (state == CHIME_OFF);
    end
  end

`ifdef BUZZ_MUTE_EN
  assign buz = buz_q & ~(mute & (state != ALARM_ON));
`else
  assign buz = buz_q;
`endif

endmodule
